// File: rtl/simd_sat_alu_pkg.sv
// Shared constants and helpers for the SIMD saturating add/sub ALU.
package simd_sat_alu_pkg;

    // Segment-size codes: segment = 8 * 2^code bits.
    localparam int unsigned W8  = 0;
    localparam int unsigned W16 = 1;
    localparam int unsigned W32 = 2;
    localparam int unsigned W64 = 3;

    localparam int unsigned LANE_W = 8;

    // Codes beyond the widest segment the datapath supports collapse onto it.
    function automatic int unsigned eff_width_code(input int unsigned code,
                                                   input int unsigned max_code);
        return (code > max_code) ? max_code : code;
    endfunction

    // Per-lane byte of the saturation constant for a segment of any size.
    // Signed limits are 0x7F..FF / 0x80..00, so only the segment's top lane
    // differs from the fill byte; unsigned limits are all ones / all zeros.
    function automatic logic [7:0] sat_lane_byte(input logic is_signed,
                                                 input logic neg,
                                                 input logic is_msb_lane,
                                                 input logic op_sub);
        logic [7:0] v;
        if (is_signed) begin
            if (neg) v = is_msb_lane ? 8'h80 : 8'h00;
            else     v = is_msb_lane ? 8'h7F : 8'hFF;
        end else begin
            v = op_sub ? 8'h00 : 8'hFF;
        end
        return v;
    endfunction

endpackage

// File: rtl/simd_seg_mask.sv
// Derives which lanes start and which lanes end a segment for a width code.
module simd_seg_mask
    import simd_sat_alu_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int MODE_W = $clog2(LANES) + 1
) (
    input  logic [MODE_W-1:0] width,
    output logic [LANES-1:0]  seg_lsb,
    output logic [LANES-1:0]  seg_msb
);

    localparam int unsigned LOG2_L = $clog2(LANES);

    // A lane starts a segment when its index is a multiple of the segment
    // lane count; it ends one when the next index is.
    always_comb begin
        int unsigned k;
        int unsigned span;
        seg_lsb = '0;
        seg_msb = '0;
        k       = eff_width_code(32'(width), LOG2_L);
        span    = (32'd1 << k) - 32'd1;
        for (int i = 0; i < LANES; i++) begin
            seg_lsb[i] = ((32'(i) & span) == 32'd0);
            seg_msb[i] = ((32'(i + 1) & span) == 32'd0);
        end
    end

endmodule

// File: rtl/simd_sat_alu.sv
// Two-stage SIMD add/subtract with per-segment overflow and saturation.
// S1 registers carry-free lane sums plus generate/propagate; S2 ripples the
// carry across each segment, detects overflow and clamps.
module simd_sat_alu
    import simd_sat_alu_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int W      = 8 * LANES,
    parameter int MODE_W = $clog2(LANES) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    input  logic [MODE_W-1:0] width,
    input  logic              op_sub,
    input  logic              is_signed,
    input  logic              saturate,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      y,
    output logic [LANES-1:0]  ovf,
    input  logic              sticky_clr,
    output logic [LANES-1:0]  ovf_sticky
);

    logic [LANES-1:0] seg_lsb_in, seg_msb_in;

    simd_seg_mask #(.LANES(LANES), .MODE_W(MODE_W)) u_seg_mask (
        .width   (width),
        .seg_lsb (seg_lsb_in),
        .seg_msb (seg_msb_in)
    );

    // Control state
    logic vld_p1_q, vld_p1_d;
    logic vld_p2_q, vld_p2_d;
    logic [LANES-1:0] sticky_q, sticky_d;

    // S1 data
    logic [W-1:0]     sum_p1_q, sum_p1_d;
    logic [LANES-1:0] gen_p1_q, gen_p1_d;
    logic [LANES-1:0] prop_p1_q, prop_p1_d;
    logic [LANES-1:0] a_sgn_p1_q, a_sgn_p1_d;
    logic [LANES-1:0] b_sgn_p1_q, b_sgn_p1_d;
    logic [LANES-1:0] seg_lsb_p1_q, seg_lsb_p1_d;
    logic [LANES-1:0] seg_msb_p1_q, seg_msb_p1_d;
    logic             op_sub_p1_q, op_sub_p1_d;
    logic             is_signed_p1_q, is_signed_p1_d;
    logic             saturate_p1_q, saturate_p1_d;

    // S2 data
    logic [W-1:0]     y_p2_q, y_p2_d;
    logic [LANES-1:0] ovf_p2_q, ovf_p2_d;

    // Combinational S2 results and handshake terms
    logic [W-1:0]     y_s2;
    logic [LANES-1:0] ovf_s2;
    logic             adv_p2, in_accept, load_p2, out_hs;

    // Handshake: each stage moves when the one after it is empty or draining.
    always_comb begin
        adv_p2    = !vld_p2_q || out_ready;
        in_ready  = !vld_p1_q || adv_p2;
        in_accept = in_valid && in_ready;
        load_p2   = vld_p1_q && adv_p2;
        out_hs    = vld_p2_q && out_ready;
        vld_p1_d  = in_ready ? in_valid : vld_p1_q;
        vld_p2_d  = adv_p2 ? vld_p1_q : vld_p2_q;
        if (out_hs)          sticky_d = sticky_clr ? ovf_p2_q : (sticky_q | ovf_p2_q);
        else if (sticky_clr) sticky_d = '0;
        else                 sticky_d = sticky_q;
    end

    // ---- S1: carry-free lane sums with generate/propagate ----
    always_comb begin
        logic [7:0] bx;
        logic [8:0] s9;
        bx             = '0;
        s9             = '0;
        sum_p1_d       = sum_p1_q;
        gen_p1_d       = gen_p1_q;
        prop_p1_d      = prop_p1_q;
        a_sgn_p1_d     = a_sgn_p1_q;
        b_sgn_p1_d     = b_sgn_p1_q;
        seg_lsb_p1_d   = seg_lsb_p1_q;
        seg_msb_p1_d   = seg_msb_p1_q;
        op_sub_p1_d    = op_sub_p1_q;
        is_signed_p1_d = is_signed_p1_q;
        saturate_p1_d  = saturate_p1_q;
        if (in_accept) begin
            for (int i = 0; i < LANES; i++) begin
                bx = op_sub ? ~b[8*i +: 8] : b[8*i +: 8];
                s9 = {1'b0, a[8*i +: 8]} + {1'b0, bx};
                sum_p1_d[8*i +: 8] = s9[7:0];
                gen_p1_d[i]        = s9[8];
                prop_p1_d[i]       = &s9[7:0];
                a_sgn_p1_d[i]      = a[8*i + 7];
                b_sgn_p1_d[i]      = bx[7];
            end
            seg_lsb_p1_d   = seg_lsb_in;
            seg_msb_p1_d   = seg_msb_in;
            op_sub_p1_d    = op_sub;
            is_signed_p1_d = is_signed;
            saturate_p1_d  = saturate;
        end
    end

    // S1 data registers carry no reset; vld_p1_q qualifies them.
    always_ff @(posedge clk) begin
        sum_p1_q       <= sum_p1_d;
        gen_p1_q       <= gen_p1_d;
        prop_p1_q      <= prop_p1_d;
        a_sgn_p1_q     <= a_sgn_p1_d;
        b_sgn_p1_q     <= b_sgn_p1_d;
        seg_lsb_p1_q   <= seg_lsb_p1_d;
        seg_msb_p1_q   <= seg_msb_p1_d;
        op_sub_p1_q    <= op_sub_p1_d;
        is_signed_p1_q <= is_signed_p1_d;
        saturate_p1_q  <= saturate_p1_d;
    end

    // ---- S2: segment carry ripple, overflow detection, saturation ----
    always_comb begin
        logic             carry, c_in, seg_ovf, seg_neg;
        logic [7:0]       lane_sum;
        logic [W-1:0]     wrap;
        logic [LANES-1:0] lane_ovf;
        carry    = 1'b0;
        c_in     = 1'b0;
        seg_ovf  = 1'b0;
        seg_neg  = 1'b0;
        lane_sum = '0;
        wrap     = '0;
        lane_ovf = '0;
        y_s2     = '0;
        // Carry into a segment's first lane is the subtract "+1"; b was
        // already inverted in S1, so op_sub doubles as that carry.
        for (int i = 0; i < LANES; i++) begin
            c_in     = seg_lsb_p1_q[i] ? op_sub_p1_q : carry;
            lane_sum = sum_p1_q[8*i +: 8] + {7'd0, c_in};
            carry    = gen_p1_q[i] | (prop_p1_q[i] & c_in);
            wrap[8*i +: 8] = lane_sum;
            if (seg_msb_p1_q[i]) begin
                if (is_signed_p1_q)
                    lane_ovf[i] = (a_sgn_p1_q[i] == b_sgn_p1_q[i]) &&
                                  (lane_sum[7] != a_sgn_p1_q[i]);
                else
                    lane_ovf[i] = op_sub_p1_q ? !carry : carry;
            end
        end
        // Walk down from the top so every lane inherits its segment's
        // overflow flag and direction from the segment's MSB lane.
        for (int i = LANES - 1; i >= 0; i--) begin
            if (seg_msb_p1_q[i]) begin
                seg_ovf = lane_ovf[i];
                seg_neg = a_sgn_p1_q[i];
            end
            if (saturate_p1_q && seg_ovf)
                y_s2[8*i +: 8] = sat_lane_byte(is_signed_p1_q, seg_neg,
                                               seg_msb_p1_q[i], op_sub_p1_q);
            else
                y_s2[8*i +: 8] = wrap[8*i +: 8];
        end
        ovf_s2 = lane_ovf;
    end

    // S2 capture happens only when the stage is free to take S1's beat.
    always_comb begin
        y_p2_d   = load_p2 ? y_s2   : y_p2_q;
        ovf_p2_d = load_p2 ? ovf_s2 : ovf_p2_q;
    end

    // S2 data registers carry no reset; vld_p2_q qualifies them.
    always_ff @(posedge clk) begin
        y_p2_q   <= y_p2_d;
        ovf_p2_q <= ovf_p2_d;
    end

    // Control registers: reset empties the pipe and clears the sticky status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            sticky_q <= '0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            sticky_q <= sticky_d;
        end
    end

    // Result data reads zero whenever no beat is presented, including reset.
    always_comb begin
        out_valid  = vld_p2_q;
        y          = vld_p2_q ? y_p2_q : '0;
        ovf        = vld_p2_q ? ovf_p2_q : '0;
        ovf_sticky = sticky_q;
    end

endmodule

// File: tb/tb_simd_sat_alu.sv
// Scoreboard bench for simd_sat_alu (LANES=4): directed vectors, stall,
// reset and sticky-clear scenarios, then randomized traffic.
module tb_simd_sat_alu;

    localparam int LANES  = 4;
    localparam int W      = 32;
    localparam int MODE_W = 3;

    typedef struct {
        logic [W-1:0]     y;
        logic [LANES-1:0] ovf;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      a, b;
    logic [MODE_W-1:0] width;
    logic              op_sub, is_signed, saturate;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      y;
    logic [LANES-1:0]  ovf;
    logic              sticky_clr;
    logic [LANES-1:0]  ovf_sticky;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;
    bit   rand_done;

    simd_sat_alu #(.LANES(LANES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .width      (width),
        .op_sub     (op_sub),
        .is_signed  (is_signed),
        .saturate   (saturate),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y          (y),
        .ovf        (ovf),
        .sticky_clr (sticky_clr),
        .ovf_sticky (ovf_sticky)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: whole segments as integers, then clamp or wrap.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input int k_in, input bit sub, input bit sgn,
                                   input bit sat);
        exp_t   e;
        int     k, n, lp;
        longint m, ua, ub, r, hi, lo, res;
        bit     ov;
        k  = (k_in > 2) ? 2 : k_in;
        n  = 8 << k;
        lp = 1 << k;
        m  = (64'sd1 <<< n) - 1;
        e.y   = '0;
        e.ovf = '0;
        for (int s = 0; s < LANES / lp; s++) begin
            ua = longint'(ma >> (s * n)) & m;
            ub = longint'(mb >> (s * n)) & m;
            if (sgn) begin
                hi = (64'sd1 <<< (n - 1)) - 1;
                lo = -(64'sd1 <<< (n - 1));
                if (ua > hi) ua = ua - (m + 1);
                if (ub > hi) ub = ub - (m + 1);
            end else begin
                hi = m;
                lo = 0;
            end
            r   = sub ? (ua - ub) : (ua + ub);
            ov  = (r > hi) || (r < lo);
            res = r;
            if (sat && ov) res = (r > hi) ? hi : lo;
            e.y = e.y | (W'(res & m) << (s * n));
            e.ovf[s * lp + lp - 1] = ov;
        end
        return e;
    endfunction

    function automatic logic [W-1:0] rand_opnd();
        logic [W-1:0] v;
        v = $urandom;
        if ($urandom_range(0, 2) == 0) begin
            for (int i = 0; i < LANES; i++) begin
                case ($urandom_range(0, 4))
                    0:       v[8*i +: 8] = 8'h00;
                    1:       v[8*i +: 8] = 8'h01;
                    2:       v[8*i +: 8] = 8'h7F;
                    3:       v[8*i +: 8] = 8'h80;
                    default: v[8*i +: 8] = 8'hFF;
                endcase
            end
        end
        return v;
    endfunction

    // Offer one beat from posedge+1; push the expectation once it is accepted.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input int tw, input bit tsub, input bit tsgn,
                        input bit tsat, input exp_t e);
        bit done;
        done      = 1'b0;
        in_valid  = 1'b1;
        a         = ta;
        b         = tb_v;
        width     = MODE_W'(tw);
        op_sub    = tsub;
        is_signed = tsgn;
        saturate  = tsat;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 300 cycles");
        end
    endtask

    task automatic send_model(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                              input int tw, input bit tsub, input bit tsgn,
                              input bit tsat);
        send(ta, tb_v, tw, tsub, tsgn, tsat, model(ta, tb_v, tw, tsub, tsgn, tsat));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares presented beats against the queue, checks stability
    // under stall, tracks the expected sticky status and the reset state.
    initial begin
        logic [LANES-1:0] exp_sticky;
        logic [W-1:0]     held_y;
        logic [LANES-1:0] held_ovf;
        bit               stalled;
        exp_t             e;
        exp_sticky = '0;
        stalled    = 1'b0;
        held_y     = '0;
        held_ovf   = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                compared++;
                if (out_valid !== 1'b0 || y !== '0 || ovf !== '0 || ovf_sticky !== '0) begin
                    mismatched++;
                    $display("FAIL reset_state: out_valid=%b y=%h ovf=%b sticky=%b, required 0/0/0/0",
                             out_valid, y, ovf, ovf_sticky);
                end
                exp_sticky = '0;
                stalled    = 1'b0;
            end else begin
                compared++;
                if (ovf_sticky !== exp_sticky) begin
                    mismatched++;
                    $display("FAIL ovf_sticky: got %b, required %b", ovf_sticky, exp_sticky);
                end
                if (stalled) begin
                    compared++;
                    if (out_valid !== 1'b1 || y !== held_y || ovf !== held_ovf) begin
                        mismatched++;
                        $display("FAIL stall_stable: out_valid=%b y=%h ovf=%b, required 1 y=%h ovf=%b",
                                 out_valid, y, ovf, held_y, held_ovf);
                    end
                end
                stalled = 1'b0;
                if (out_valid === 1'b1) begin
                    if (sb.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_beat: got y=%h ovf=%b, required no beat", y, ovf);
                    end else begin
                        e = sb[0];
                        compared++;
                        if (y !== e.y || ovf !== e.ovf) begin
                            mismatched++;
                            $display("FAIL result: got y=%h ovf=%b, required y=%h ovf=%b",
                                     y, ovf, e.y, e.ovf);
                        end
                        if (out_ready) begin
                            void'(sb.pop_front());
                            exp_sticky = sticky_clr ? e.ovf : (exp_sticky | e.ovf);
                        end else begin
                            stalled  = 1'b1;
                            held_y   = y;
                            held_ovf = ovf;
                            if (sticky_clr) exp_sticky = '0;
                        end
                    end
                end else if (sticky_clr) begin
                    exp_sticky = '0;
                end
            end
        end
    end

    initial begin
        exp_t e;
        rst_n      = 1'b1;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        width      = '0;
        op_sub     = 1'b0;
        is_signed  = 1'b0;
        saturate   = 1'b0;
        out_ready  = 1'b1;
        sticky_clr = 1'b0;
        rand_done  = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 32-bit signed wrap, then the two directed saturation vectors.
        e.y = 32'h80000000; e.ovf = 4'b1000;
        send(32'h7FFFFFFF, 32'h00000001, 2, 1'b0, 1'b1, 1'b0, e);
        e.y = 32'h7F7E0280; e.ovf = 4'b1001;
        send(32'h7F7F0180, 32'h01FF0180, 0, 1'b0, 1'b1, 1'b1, e);
        e.y = 32'h00000FFF; e.ovf = 4'b1000;
        send(32'h00051000, 32'h00060001, 1, 1'b1, 1'b0, 1'b1, e);
        idle(6);

        // Clear coinciding with an overflowing beat's handshake.
        e.y = 32'h000000FF; e.ovf = 4'b0001;
        send(32'h000000FF, 32'h00000001, 0, 1'b0, 1'b0, 1'b1, e);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid) begin
                sticky_clr = 1'b1;
                @(posedge clk);
                #1 sticky_clr = 1'b0;
                break;
            end
        end
        idle(3);

        // Eight back-to-back beats with out_ready low for three cycles.
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send_model(rand_opnd(), rand_opnd(), i % 4, i[0], i[1], i[2]);
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle(8);

        // Reset with two beats in flight.
        send_model(32'h11223344, 32'h55667788, 0, 1'b0, 1'b0, 1'b0);
        send_model(32'h7FFF8000, 32'h00010001, 1, 1'b0, 1'b1, 1'b1);
        rst_n = 1'b0;
        sb.delete();
        idle(2);
        rst_n = 1'b1;
        idle(6);

        // Randomized traffic with random back-pressure and clears.
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    if ($urandom_range(0, 3) == 0) idle(1);
                    sticky_clr = ($urandom_range(0, 9) == 0);
                    send_model(rand_opnd(), rand_opnd(), $urandom_range(0, 7),
                               1'($urandom), 1'($urandom), 1'($urandom));
                    sticky_clr = 1'b0;
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join

        for (int t = 0; t < 500 && sb.size() != 0; t++) idle(1);
        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d beats outstanding, required 0", sb.size());
        end
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/simd_sat_alu.md
SIMD_SAT_ALU -- requirements
Module: simd_sat_alu

Interface
REQ-001 SHALL have parameter LANES, default 4, number of 8-bit lanes; power of 2, 2..16.
REQ-002 SHALL have parameter W = 8*LANES (derived), datapath width.
REQ-003 SHALL have parameter MODE_W = $clog2(LANES)+1 (derived), width of the segment-size code.
REQ-004 clk  input  1  rising-edge clock, single clock domain.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  operand beat offered.
REQ-007 in_ready  output  1  operand beat accepted when in_valid && in_ready.
REQ-008 a, b  input  W each  operands.
REQ-009 width  input  MODE_W  segment size code k: segment = 8*2^k bits; k > log2(LANES) treated as log2(LANES).
REQ-010 op_sub  input  1  0: a+b; 1: a-b.
REQ-011 is_signed  input  1  1: two's-complement segments; 0: unsigned segments.
REQ-012 saturate  input  1  1: clamp on overflow; 0: wrap.
REQ-013 out_valid  output  1  result beat present.
REQ-014 out_ready  input  1  result beat consumed when out_valid && out_ready.
REQ-015 y  output  W  result.
REQ-016 ovf  output  LANES  per-beat overflow; bit set only at most-significant lane of an overflowing segment.
REQ-017 sticky_clr  input  1  clear of accumulated overflow status.
REQ-018 ovf_sticky  output  LANES  OR of ovf over all consumed beats since last clear/reset.

Function
REQ-019 Two-stage pipeline: S1 registers per-lane 8-bit partial sums and lane carries; S2 resolves carry chain across segment, detects overflow, applies saturation, registers y/ovf.
REQ-020 Latency: beat accepted in cycle N SHALL appear on y in cycle N+2 when out_ready is held high.
REQ-021 Throughput one beat per cycle with out_ready high; no bubble insertion.
REQ-022 Carry into lane i SHALL be carry-out of lane i-1 when both in same segment, else op_sub (0 for add, 1 for sub; b inverted per lane for sub).
REQ-023 Signed overflow: operand sign bits of segment MSB (with b inverted for sub) equal and differ from result sign.
REQ-024 Unsigned overflow: add -> segment carry-out 1; sub -> segment carry-out 0 (borrow).
REQ-025 Saturation (saturate=1, overflow): signed positive -> 0x7F..FF, signed negative -> 0x80..00, unsigned add -> all ones, unsigned sub -> all zeros, over whole segment only.
REQ-026 saturate=0: y = wrapped sum; ovf still reported.
REQ-027 Handshake: each stage advances when downstream empty or consuming; in_ready = !S1_valid || S1 advances; out_valid/y/ovf SHALL remain stable while out_valid && !out_ready.
REQ-028 in_valid without in_ready SHALL NOT alter pipeline contents; mode inputs sampled with the beat.
REQ-029 ovf_sticky updates on output handshake: sticky_clr and handshake same cycle -> ovf_sticky = ovf of that beat; sticky_clr alone -> 0.

Reset
REQ-030 rst_n low SHALL immediately clear S1_valid, out_valid, ovf_sticky; y and ovf SHALL read 0.
REQ-031 Reset mid-operation SHALL drop all in-flight beats; no beat emitted after reset release until new input accepted.
REQ-032 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-033 Shared package SHALL hold width-code constants (W8=0, W16=1, W32=2, W64=3) and saturation-constant function per segment size.
REQ-034 One sub-module simd_seg_mask SHALL derive per-lane segment-boundary and segment-MSB masks from width and LANES; instantiated once.

Verification (LANES=4)
REQ-035 width=0, signed, sat, add, a=0x7F7F0180, b=0x01FF0180 -> y=0x7F7E027F? no: lanes: 7F+01 sat 7F, 7F+FF=7E, 01+01=02, 80+80 sat 80 -> y=0x7F7E0280, ovf=0b1001.
REQ-036 width=1, unsigned, sat, sub, a=0x00051000, b=0x00060001 -> y=0x00000FFF, ovf=0b1000.
REQ-037 width=2, signed, sat=0, add, a=0x7FFFFFFF, b=1 -> y=0x80000000, ovf=0b1000; ovf_sticky=0b1000 after handshake.
REQ-038 Back-to-back 8 beats, out_ready low cycles 3-5 -> all 8 results in order, none lost/duplicated, y stable during stall.
REQ-039 rst_n pulsed low with 2 beats in flight -> out_valid 0 immediately, no stale beat after release, ovf_sticky=0.
REQ-040 sticky_clr concurrent with overflowing beat handshake -> ovf_sticky equals that beat's ovf only.
